// File: rtl/multibank_frame_buffer_pkg.sv
// Shared types for the multibank frame buffer.
// Bank lifecycle states, overflow policy encoding, drop counter width.
package multibank_frame_buffer_pkg;

  typedef enum logic [1:0] {
    FREE,
    FILLING,
    FULL,
    READING
  } bank_state_e;

  typedef enum logic {
    OVF_BLOCK,
    OVF_DROP
  } ovf_mode_e;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/frame_buffer_sdp_ram.sv
// Simple dual-port RAM, one write port, one registered read port.
// Ports: clk_i, we_i/waddr_i/wdata_i write side; re_i/raddr_i -> rdata_o.
module frame_buffer_sdp_ram #(
  parameter int WIDTH  = 32,
  parameter int WORDS  = 48,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/multibank_frame_buffer.sv
// Rotating N-bank frame buffer between a valid/ready producer and consumer.
// Ports: frame_len_i/ovf_mode_i/ovf_clear_i control, write_* producer,
// read_* consumer, banks_full_o/buffer_overflow_o/drop_count_o/
// write_count_o/read_count_o status.
module multibank_frame_buffer
  import multibank_frame_buffer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int NUM_BANKS = 3,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [CNT_W-1:0]               frame_len_i,
  input  logic                           ovf_mode_i,
  input  logic                           ovf_clear_i,
  input  logic [WIDTH-1:0]               write_data_i,
  input  logic                           write_valid_i,
  output logic                           write_ready_o,
  output logic [WIDTH-1:0]               read_data_o,
  output logic                           read_valid_o,
  input  logic                           read_ready_i,
  output logic                           read_last_o,
  output logic [$clog2(NUM_BANKS+1)-1:0] banks_full_o,
  output logic                           buffer_overflow_o,
  output logic [DROP_CNT_W-1:0]          drop_count_o,
  output logic [CNT_W-1:0]               write_count_o,
  output logic [CNT_W-1:0]               read_count_o
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ADDR_W = BANK_W + IDX_W;
  localparam int BF_W   = $clog2(NUM_BANKS + 1);

  function automatic logic [BANK_W-1:0] bump(
    input logic [BANK_W-1:0] b
  );
    return (b == BANK_W'(NUM_BANKS - 1)) ?
      '0 : b + BANK_W'(1);
  endfunction

  bank_state_e            st_q  [NUM_BANKS];
  logic [CNT_W-1:0]       len_q [NUM_BANKS];

  logic [BANK_W-1:0]      wr_bank_q;
  logic [BANK_W-1:0]      iss_bank_q;
  logic [BANK_W-1:0]      rd_bank_q;
  logic [CNT_W-1:0]       wr_cnt_q;
  logic [CNT_W-1:0]       cur_len_q;
  logic [CNT_W-1:0]       iss_cnt_q;
  logic [CNT_W-1:0]       rd_cnt_q;
  logic                   drop_q;
  ovf_mode_e              mode_q;
  logic                   ovf_q;
  logic [DROP_CNT_W-1:0]  drop_cnt_q;

  logic                   p1_v_q;
  logic                   p1_last_q;
  logic                   out_v_q;
  logic                   out_last_q;
  logic [WIDTH-1:0]       out_data_q;
  logic                   sk_v_q;
  logic                   sk_last_q;
  logic [WIDTH-1:0]       sk_data_q;

  logic                   frame_start;
  logic [CNT_W-1:0]       in_len;
  logic [CNT_W-1:0]       len_now;
  logic                   wr_fire;
  logic                   drop_now;
  logic                   wr_last;
  logic                   ram_we;
  logic                   ovf_set;

  logic [CNT_W-1:0]       iss_len;
  logic                   iss_ok;
  logic                   iss_last;
  logic [1:0]             inflight;
  logic                   fire;
  logic                   room;
  logic                   ram_re;
  logic [WIDTH-1:0]       ram_q;
  logic [BF_W-1:0]        full_cnt;

  // Write side
  assign frame_start = (wr_cnt_q == '0);
  assign in_len = (frame_len_i == '0 ||
                   frame_len_i > CNT_W'(DEPTH)) ?
                  CNT_W'(DEPTH) : frame_len_i;
  assign len_now = frame_start ? in_len : cur_len_q;

  // Only registered state: mode_q is frozen for the frame in flight.
  assign write_ready_o =
    (st_q[wr_bank_q] == FREE) ||
    (st_q[wr_bank_q] == FILLING) ||
    (mode_q == OVF_DROP);

  assign wr_fire  = write_valid_i && write_ready_o;
  assign drop_now = frame_start ?
                    (st_q[wr_bank_q] != FREE) : drop_q;
  assign wr_last  = (wr_cnt_q == len_now - CNT_W'(1));
  assign ram_we   = wr_fire && !drop_now;
  assign ovf_set  = wr_fire && wr_last && drop_now;

  // Read issue side: runs ahead of the consumer by the pipeline depth.
  assign iss_len  = len_q[iss_bank_q];
  assign iss_ok   = (iss_cnt_q == '0) ?
                    (st_q[iss_bank_q] == FULL) : 1'b1;
  assign iss_last = (iss_cnt_q == iss_len - CNT_W'(1));
  assign fire     = out_v_q && read_ready_i;
  assign inflight = {1'b0, p1_v_q} + {1'b0, out_v_q} +
                    {1'b0, sk_v_q};
  // Output reg plus skid hold two words; the word issued now
  // lands two edges later, so count it against that room.
  assign room     = fire ? (inflight <= 2'd2) :
                           (inflight <= 2'd1);
  assign ram_re   = iss_ok && room;

  always_comb begin
    full_cnt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (st_q[b] == FULL || st_q[b] == READING)
        full_cnt = full_cnt + BF_W'(1);
    end
  end

  frame_buffer_sdp_ram #(
    .WIDTH (WIDTH),
    .WORDS (NUM_BANKS * DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .waddr_i({wr_bank_q, wr_cnt_q[IDX_W-1:0]}),
    .wdata_i(write_data_i),
    .re_i   (ram_re),
    .raddr_i({iss_bank_q, iss_cnt_q[IDX_W-1:0]}),
    .rdata_o(ram_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        st_q[b]  <= FREE;
        len_q[b] <= '0;
      end
      wr_bank_q  <= '0;
      iss_bank_q <= '0;
      rd_bank_q  <= '0;
      wr_cnt_q   <= '0;
      cur_len_q  <= '0;
      iss_cnt_q  <= '0;
      rd_cnt_q   <= '0;
      drop_q     <= 1'b0;
      mode_q     <= OVF_BLOCK;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
      p1_v_q     <= 1'b0;
      p1_last_q  <= 1'b0;
      out_v_q    <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
      sk_v_q     <= 1'b0;
      sk_last_q  <= 1'b0;
      sk_data_q  <= '0;
    end else begin
      // Bank states: each transition needs a distinct source
      // state, so at most one applies per bank per edge.
      if (ram_we) begin
        if (frame_start) len_q[wr_bank_q] <= len_now;
        st_q[wr_bank_q] <= wr_last ? FULL : FILLING;
      end
      if (ram_re && iss_cnt_q == '0)
        st_q[iss_bank_q] <= READING;
      if (fire && out_last_q)
        st_q[rd_bank_q] <= FREE;

      // Producer frame tracking
      if (wr_fire) begin
        if (frame_start) begin
          cur_len_q <= len_now;
          drop_q    <= drop_now;
        end
        if (wr_last) begin
          wr_cnt_q <= '0;
          mode_q   <= ovf_mode_e'(ovf_mode_i);
          if (drop_now) begin
            if (drop_cnt_q != '1)
              drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
          end else begin
            wr_bank_q <= bump(wr_bank_q);
          end
        end else begin
          wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        end
      end else if (frame_start) begin
        mode_q <= ovf_mode_e'(ovf_mode_i);
      end

      if (ovf_set)
        ovf_q <= 1'b1;
      else if (ovf_clear_i)
        ovf_q <= 1'b0;

      // RAM read issue
      if (ram_re) begin
        if (iss_last) begin
          iss_cnt_q  <= '0;
          iss_bank_q <= bump(iss_bank_q);
        end else begin
          iss_cnt_q <= iss_cnt_q + CNT_W'(1);
        end
      end
      p1_v_q    <= ram_re;
      p1_last_q <= ram_re && iss_last;

      // Output register with one-entry skid behind it
      if (fire) begin
        if (sk_v_q) begin
          out_data_q <= sk_data_q;
          out_last_q <= sk_last_q;
          if (p1_v_q) begin
            sk_data_q <= ram_q;
            sk_last_q <= p1_last_q;
          end else begin
            sk_v_q <= 1'b0;
          end
        end else if (p1_v_q) begin
          out_data_q <= ram_q;
          out_last_q <= p1_last_q;
        end else begin
          out_v_q    <= 1'b0;
          out_last_q <= 1'b0;
        end
      end else if (p1_v_q) begin
        if (!out_v_q) begin
          out_v_q    <= 1'b1;
          out_data_q <= ram_q;
          out_last_q <= p1_last_q;
        end else begin
          sk_v_q    <= 1'b1;
          sk_data_q <= ram_q;
          sk_last_q <= p1_last_q;
        end
      end

      // Consumer frame tracking
      if (fire) begin
        if (out_last_q) begin
          rd_cnt_q  <= '0;
          rd_bank_q <= bump(rd_bank_q);
        end else begin
          rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign read_data_o       = out_data_q;
  assign read_valid_o      = out_v_q;
  assign read_last_o       = out_last_q;
  assign banks_full_o      = full_cnt;
  assign buffer_overflow_o = ovf_q;
  assign drop_count_o      = drop_cnt_q;
  assign write_count_o     = wr_cnt_q;
  assign read_count_o      = rd_cnt_q;

endmodule

// File: doc/multibank_frame_buffer.md
Name: multibank_frame_buffer

Overview:
- Parametrised successor to the two-bank ping-pong sample buffer.
- Rotates NUM_BANKS frame banks (≥2) between one producer and one consumer, both valid/ready.
- Adds: a run-time frame length, a selectable overflow policy, a frame-end marker on read, swap with no dead cycle, and a full-rate registered read path.
- Sits between the sample-producing front end and the frame-processing consumer.

Parameters:
- WIDTH, 32, sample width in bits (signed data).
- DEPTH, 16, maximum words per bank; power of two, ≥2.
- NUM_BANKS, 3, number of rotating banks; ≥2.
- CNT_W, $clog2(DEPTH)+1, width of the word counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- frame_len_i  in  CNT_W  words per frame; valid range 1..DEPTH; 0 or >DEPTH means DEPTH
- ovf_mode_i  in  1  0 = BLOCK, 1 = DROP
- ovf_clear_i  in  1  clears the sticky overflow flag
- write_data_i  in  WIDTH  sample in
- write_valid_i  in  1  producer valid
- write_ready_o  out  1  producer ready
- read_data_o  out  WIDTH  sample out
- read_valid_o  out  1  consumer valid
- read_ready_i  in  1  consumer ready
- read_last_o  out  1  high with the last word of a frame
- banks_full_o  out  $clog2(NUM_BANKS+1)  number of banks full or being read
- buffer_overflow_o  out  1  sticky overflow flag
- drop_count_o  out  16  count of discarded frames, saturating
- write_count_o  out  CNT_W  words written into the current frame
- read_count_o  out  CNT_W  words handed out from the current frame

Behaviour:
- Reset values (rst_i sampled high at a clock edge):
  - All banks FREE; write and read bank pointers = 0.
  - write_count_o = 0, read_count_o = 0, banks_full_o = 0, drop_count_o = 0.
  - read_valid_o = 0, read_last_o = 0, buffer_overflow_o = 0.
  - write_ready_o = 1 from the first cycle after reset.
  - A reset mid-frame discards all data; nothing partial is ever presented.
- Bank state per bank: FREE → FILLING → FULL → READING → FREE. Each bank stores the frame length latched for it.
- frame_len_i is sampled on the first accepted write of each frame. Changes mid-frame have no effect.
- Write transfer occurs when write_valid_i && write_ready_o.
  - The word goes to {wr_bank, write_count}, and write_count increments.
  - On the transfer with write_count == len−1, on the same edge:
    - the bank becomes FULL;
    - write_count becomes 0;
    - wr_bank advances modulo NUM_BANKS.
  - The next cycle may write the next bank, so there is no swap bubble.
- write_ready_o is computed from registered state only.
  - It is 1 when the target bank is FREE or FILLING.
  - It is also 1 in DROP mode.
  - A bank freed on edge N is writable from cycle N+1.
- BLOCK mode, target bank not FREE: write_ready_o = 0 until that bank is freed. No data is lost.
- DROP mode, target bank not FREE at frame start:
  - The entire incoming frame is accepted and discarded; write_count still counts it.
  - At the end of that frame, drop_count_o increments (saturating at 0xFFFF), buffer_overflow_o is set, and wr_bank does not advance.
  - Frame alignment is preserved.
- ovf_mode_i changes take effect only at a frame boundary (write_count == 0).
- buffer_overflow_o stays set until ovf_clear_i. If set and clear happen on the same edge, set wins.
- Read path:
  - The oldest FULL bank becomes READING.
  - The synchronous RAM read (1 cycle) feeds an output register plus a one-entry skid buffer.
  - read_valid_o rises exactly 2 cycles after the edge that filled the bank, provided no other frame is being read.
  - With read_ready_i held high, throughput is 1 word per clock, including across back-to-back frames.
  - read_data_o and read_last_o are held stable while read_valid_o && !read_ready_i.
  - read_last_o = 1 exactly when read_count == len−1.
  - On the transfer that carries read_last_o, the bank becomes FREE and read_count returns to 0.
- Simultaneous events:
  - A frame completing and a bank being freed on the same edge: both take effect, and banks_full_o nets out.
  - A write into a bank and a read of a different bank: no interaction.
- read_valid_o never asserts with banks_full_o = 0.

Decomposition:
- Package multibank_frame_buffer_pkg holds:
  - typedef bank_state_e {FREE, FILLING, FULL, READING};
  - typedef ovf_mode_e {OVF_BLOCK, OVF_DROP};
  - localparam DROP_CNT_W = 16.
- One sub-module, frame_buffer_sdp_ram:
  - simple dual-port RAM of NUM_BANKS*DEPTH × WIDTH;
  - address {bank, index};
  - 1-cycle registered read.
- Bank bookkeeping, counters and the skid/output stage stay in the top module.

Test Plan (WIDTH=32, DEPTH=16, NUM_BANKS=3):
- Reset: hold rst_i high 3 cycles mid-frame → next cycle write_ready_o=1, read_valid_o=0, and write_count_o, read_count_o, banks_full_o all 0.
- frame_len_i=16: write 0x1000..0x100F back-to-back → write_count_o returns to 0 on the 16th edge; read_valid_o high 2 cycles later. Reading with read_ready_i=1 yields 0x1000..0x100F on consecutive cycles, with read_last_o only on 0x100F.
- frame_len_i=5, then 16 mid-frame: write 5 words → frame ends at 5 words and the next frame uses 16. Reads return 5 words then 16, with read_last_o on the 5th and 21st word.
- BLOCK mode, consumer stalled: write 48 words → write_ready_o drops after the 48th. Releasing read_ready_i for one full frame → write_ready_o returns the cycle after read_last_o is accepted. No data lost.
- DROP mode, consumer stalled: write 4 frames (0xA000+i, …) → write_ready_o stays 1, the 4th frame is discarded, drop_count_o=1, buffer_overflow_o=1. Frames 1–3 read back intact. ovf_clear_i clears the flag.
- Random read_ready_i backpressure across 10 frames → read_data_o stable while stalled; output sequence equals input sequence exactly.
